// File: rtl/layer_pkg.sv
// Shared constants for the pooling/conv layer chain: divide-by-9 reciprocal and FSM encoding.
package layer_pkg;

  localparam int unsigned AVG9_RECIP = 7282;
  localparam int unsigned AVG9_SHIFT = 16;
  localparam int unsigned AVG9_RND   = 1 << 15;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t FILL   = 2'd1;
  localparam state_t STREAM = 2'd2;
  localparam state_t FLUSH  = 2'd3;

endpackage

// File: rtl/window_buf_33.sv
// 3x3 raster window over a 2W+3-tap line: tap 0 is the incoming sample, taps 1..2W+2 registered.
// Taps are exposed row-major, top-left first, relative to the window centre.
module window_buf_33 #(
  parameter int unsigned IMG_WIDTH  = 35,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      en,
  input  logic [DATA_WIDTH-1:0]     din,
  output logic [8:0][DATA_WIDTH-1:0] taps
);

  localparam int unsigned W     = IMG_WIDTH;
  localparam int unsigned DEPTH = 2 * W + 2;

  // No reset: stale contents are always masked out by the consumer.
  logic [DATA_WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) begin
        sr[k] <= sr[k-1];
      end
    end
  end

  // sr[k] holds the sample accepted k+1 steps ago.
  assign taps[0] = sr[2*W+1];
  assign taps[1] = sr[2*W];
  assign taps[2] = sr[2*W-1];
  assign taps[3] = sr[W+1];
  assign taps[4] = sr[W];
  assign taps[5] = sr[W-1];
  assign taps[6] = sr[1];
  assign taps[7] = sr[0];
  assign taps[8] = din;

endmodule

// File: rtl/avg_pool_33_p.sv
// 3x3 stride-1 average pool with zero "same" padding, count_include_pad, streaming raster order.
module avg_pool_33_p
  import layer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 35,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(IMG_WIDTH);
  localparam int unsigned SW = DATA_WIDTH + 4;
  localparam int unsigned PW = DATA_WIDTH + AVG9_SHIFT;
  localparam logic [CW-1:0] LAST = CW'(IMG_WIDTH - 1);

  state_t state_q, state_d;
  logic [CW-1:0] in_row_q, in_col_q, out_row_q, out_col_q;
  logic accept, fire, in_at_trig, last_in, last_out, shift_en;
  logic [8:0][DATA_WIDTH-1:0] taps;
  logic [2:0] row_ok, col_ok;
  logic [8:0] tap_keep;
  logic signed [SW-1:0] sum;
  logic [PW-1:0] rounded;
  logic [DATA_WIDTH-1:0] avg;

  assign accept     = valid_in && (state_q != FLUSH);
  assign in_at_trig = (in_row_q == CW'(1)) && (in_col_q == CW'(1));
  assign last_in    = (in_row_q == LAST) && (in_col_q == LAST);
  assign last_out   = (out_row_q == LAST) && (out_col_q == LAST);
  assign fire       = (state_q == FLUSH) ||
                      (accept && ((state_q == STREAM) || (state_q == FILL && in_at_trig)));
  assign shift_en   = accept || (state_q == FLUSH);
  assign busy       = (state_q == FLUSH);

  window_buf_33 #(
    .IMG_WIDTH (IMG_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_window (
    .clk (clk),
    .en  (shift_en),
    .din (pxl_in),
    .taps(taps)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FILL;
      FILL:    if (accept && in_at_trig) state_d = STREAM;
      STREAM:  if (accept && last_in) state_d = FLUSH;
      FLUSH:   if (last_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Padding is decided from the output position, never from buffer contents.
  always_comb begin
    row_ok = {out_row_q != LAST, 1'b1, out_row_q != '0};
    col_ok = {out_col_q != LAST, 1'b1, out_col_q != '0};
    for (int t = 0; t < 9; t++) begin
      tap_keep[t] = row_ok[t / 3] && col_ok[t % 3];
    end
  end

  always_comb begin
    sum = '0;
    for (int t = 0; t < 9; t++) begin
      if (tap_keep[t]) sum = sum + SW'($signed(taps[t]));
    end
  end

  // Modulo-2^PW arithmetic keeps bits [PW-1:AVG9_SHIFT] of the signed product exact.
  assign rounded = PW'(sum) * PW'(AVG9_RECIP) + PW'(AVG9_RND);
  assign avg     = DATA_WIDTH'(rounded >> AVG9_SHIFT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      in_row_q  <= '0;
      in_col_q  <= '0;
      out_row_q <= '0;
      out_col_q <= '0;
      valid_out <= 1'b0;
      pxl_out   <= '0;
    end else begin
      state_q   <= state_d;
      valid_out <= fire;
      if (fire) pxl_out <= avg;
      if (accept) begin
        if (in_col_q == LAST) begin
          in_col_q <= '0;
          in_row_q <= (in_row_q == LAST) ? '0 : in_row_q + CW'(1);
        end else begin
          in_col_q <= in_col_q + CW'(1);
        end
      end
      if (fire) begin
        if (out_col_q == LAST) begin
          out_col_q <= '0;
          out_row_q <= (out_row_q == LAST) ? '0 : out_row_q + CW'(1);
        end else begin
          out_col_q <= out_col_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_avg_pool_33_p.sv
// Scoreboard bench for avg_pool_33_p: golden 2D pooling model feeds a queue popped on valid_out.
module tb_avg_pool_33_p;

  localparam int W = 35;
  localparam int N = W * W;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pxl_in;
  logic [31:0] pxl_out;
  logic        valid_out;
  logic        busy;

  logic [31:0] frame [N];
  logic [31:0] sb_q [$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          vo_count = 0;
  int          exp_pulses = 0;
  logic        exp_vo_drv = 1'b0;
  logic        exp_vo_q = 1'b0;
  logic        exp_busy_drv = 1'b0;

  avg_pool_33_p #(
    .IMG_WIDTH (W),
    .DATA_WIDTH(32)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .valid_in (valid_in),
    .pxl_in   (pxl_in),
    .pxl_out  (pxl_out),
    .valid_out(valid_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk) exp_vo_q <= exp_vo_drv;

  always @(negedge clk) begin
    if (reset) begin
      if (valid_out || exp_vo_q) check("valid_out", longint'(valid_out), longint'(exp_vo_q));
      if (busy || exp_busy_drv) check("busy", longint'(busy), longint'(exp_busy_drv));
      if (valid_out) begin
        vo_count++;
        if (sb_q.size() == 0) check("unexpected_out", 1, 0);
        else check("pxl_out", longint'(pxl_out), longint'(sb_q.pop_front()));
      end
    end
  end

  // Reference: zero-padded 3x3 sum, divisor fixed at 9 via the rounded reciprocal.
  task automatic push_expected();
    for (int r = 0; r < W; r++) begin
      for (int c = 0; c < W; c++) begin
        longint s = 0;
        longint p;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (r + dr >= 0 && r + dr < W && c + dc >= 0 && c + dc < W)
              s += longint'($signed(frame[(r + dr) * W + c + dc]));
          end
        end
        p = (s * 7282 + 32768) >>> 16;
        sb_q.push_back(p[31:0]);
      end
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] px, input bit evo, input bit eb);
    @(posedge clk);
    #1;
    valid_in     = v;
    pxl_in       = px;
    exp_vo_drv   = evo;
    exp_busy_drv = eb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input int gap_pct, input bit noisy_flush, input int stop_after);
    push_expected();
    for (int k = 0; k < N; k++) begin
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) drive(1'b0, $urandom, 1'b0, 1'b0);
      drive(1'b1, frame[k], k >= W + 1, 1'b0);
      if (k >= W + 1) exp_pulses++;
      if (stop_after > 0 && k == stop_after - 1) return;
    end
    // Flush: outputs every cycle, any valid_in here must be ignored.
    for (int f = 0; f <= W; f++) begin
      drive(noisy_flush ? 1'($urandom_range(1)) : 1'b0, $urandom, 1'b1, 1'b1);
      exp_pulses++;
    end
  endtask

  task automatic fill_const(input logic [31:0] v);
    for (int k = 0; k < N; k++) frame[k] = v;
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < N; k++) frame[k] = k << 16;
  endtask

  task automatic end_scenario(input string tag);
    idle(4);
    check({tag, "_pulses"}, longint'(vo_count), longint'(exp_pulses));
    check({tag, "_sb_left"}, longint'(sb_q.size()), 0);
  endtask

  initial begin
    reset    = 1'b0;
    valid_in = 1'b0;
    pxl_in   = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_valid_out", longint'(valid_out), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_pxl_out", longint'(pxl_out), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);

    fill_const(32'h005A_0000);
    run_frame(0, 1'b0, 0);
    end_scenario("const90");

    fill_const(32'h0);
    frame[17 * W + 17] = 32'h0009_0000;
    run_frame(0, 1'b0, 0);
    end_scenario("impulse");

    fill_ramp();
    run_frame(30, 1'b0, 0);
    end_scenario("ramp_gaps");

    fill_const(32'hFFF7_0000);
    run_frame(0, 1'b0, 0);
    end_scenario("neg9");

    // Abort mid-STREAM, then a fresh frame must match the clean 90.0 result.
    fill_const(32'h005A_0000);
    run_frame(0, 1'b0, 500);
    idle(1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("mid_rst_valid_out", longint'(valid_out), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_pxl_out", longint'(pxl_out), 0);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    run_frame(0, 1'b0, 0);
    end_scenario("after_rst");

    fill_const(32'h005A_0000);
    run_frame(0, 1'b1, 0);
    fill_ramp();
    run_frame(0, 1'b1, 0);
    end_scenario("back2back");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/avg_pool_33_p.md
# avg_pool_33_p

3x3 average-pool layer, stride 1, "same" zero padding, single channel plane per frame, streaming raster order. It sits directly downstream of the stem output (35x35 planes) and forms the pooling branch feeding the first Inception-A block's 1x1 convolution. It accepts one pixel per `valid_in` with no backpressure, like the rest of the layer chain, and emits a same-size IMG_WIDTH x IMG_WIDTH plane.

## Interface
- `IMG_WIDTH`, 35: square plane side, in pixels; must be ≥ 3.
- `DATA_WIDTH`, 32: pixel width, signed two's complement, Q16.16.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- `valid_in`  in  1  `pxl_in` is a valid sample this cycle.
- `pxl_in`  in  DATA_WIDTH  input pixel, raster order, row 0 col 0 first.
- `pxl_out`  out  DATA_WIDTH  averaged pixel; reset value 0.
- `valid_out`  out  1  `pxl_out` is valid this cycle; reset value 0.
- `busy`  out  1  high while FLUSH emits tail outputs; reset value 0.

## Operation
- Window: a shift register of 2*IMG_WIDTH+3 samples, advanced only on accepted input (or flush step). It holds linear indices i-2W-2 … i.
- Output index n = (r,c) is triggered when input index n+W+1 is accepted (W = IMG_WIDTH). The window is then centred on (r,c).
- Padding mask: window taps with row −1, row W, col −1 or col W contribute 0. The mask is derived from output counters `out_row`/`out_col`, not from buffer contents.
- sum = signed sum of 9 masked taps, DATA_WIDTH+4 bits.
- avg = (sum*7282 + 2^15) >>> 16, with the low DATA_WIDTH bits kept. The divisor is always 9, including padded positions (count_include_pad).
- FSM:
  - IDLE: counters 0. First valid_in → FILL.
  - FILL: no output until input index W+1 is accepted → STREAM.
  - STREAM: one output per accepted input. Accepting the last input (index W*W−1) → FLUSH.
  - FLUSH: `busy`=1. Emits the remaining W+1 outputs on W+1 consecutive cycles, with missing taps treated as padding. `valid_in` is ignored and samples are dropped. After the last output → IDLE, and the next frame may start the following cycle.
- Idle gaps on `valid_in` in FILL/STREAM stall the window. No output is produced in gap cycles.
- Counters wrap per frame: `in_col` W−1→0 increments `in_row`; `out_col` likewise.
- Reset, async at any time: state IDLE, all counters 0, `valid_out`/`busy`/`pxl_out` 0. Line buffer contents are not cleared, since masking guarantees stale data is never used.

## Timing
- Output latency: output (r,c) is registered on the edge after the trigger input is accepted. `valid_out` is high for exactly one cycle per output.
- Total per frame: W*W outputs.
- The first `valid_out` comes 1 cycle after input index W+1 is accepted.
- The last `valid_out` comes W+1 cycles after the last input is accepted.
- With back-to-back input, a frame occupies W*W + W + 2 cycles from first input to last output.
- Sum and multiply are combinational between window and output register. This is a single stage; no extra pipelining.

## Structure
- Shared package `layer_pkg` holds `AVG9_RECIP = 7282`, `AVG9_SHIFT = 16`, `AVG9_RND = 1<<15`, and the FSM state enum (IDLE, FILL, STREAM, FLUSH).
- Sub-module `window_buf_33`: a parameterised 2W+3 tap shift register with enable, exposing the 9 window taps. It is reusable by later pooling/conv stages.
- The top-level holds the FSM, counters, mask, and arithmetic.

## Test plan
- All pixels 90.0 (0x005A0000), W=35, back-to-back input:
  - interior outputs = 90.0
  - edge outputs = 60.0
  - corner outputs = 40.0
  - exactly 1225 `valid_out` pulses, last one 36 cycles after the last input.
- Single impulse 9.0 at (17,17), rest 0: outputs (16..18,16..18) = 1.0, all others 0.
- Ramp pxl = r*W+c (integer Q16.16) with random `valid_in` gaps: output matches a reference model bit-exactly, no `valid_out` in gap cycles, output order raster.
- Negative values: all pixels −9.0 → interior −9.0, corner −4.0; checks arithmetic shift and rounding.
- Reset asserted mid-STREAM (after 500 inputs), then a fresh full frame of 90.0 → no stale contribution; results identical to the first scenario.
- Two frames back-to-back, the second starting the cycle after FLUSH ends, and `valid_in` pulsed during FLUSH → pulses ignored; both frames are correct with 1225 outputs each.
